// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RV32I writeback stage: load alignment/extension, register-file write, retire count.
module writeback_stage #(
   parameter int data_width = 32,
   parameter int num_reg    = 32,
   parameter int idx_width  = $clog2(num_reg),
   parameter int cnt_width  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic [idx_width-1:0]  in_rd,
   input  logic [1:0]            in_wb_sel,
   input  logic [2:0]            in_funct3,
   input  logic [data_width-1:0] in_alu_result,
   input  logic [data_width-1:0] in_pc,
   input  logic                  mem_rvalid,
   input  logic [data_width-1:0] mem_rdata,
   output logic                  wb_en,
   output logic [idx_width-1:0]  wb_rd,
   output logic [data_width-1:0] wb_data,
   output logic                  retire,
   output logic                  misaligned,
   output logic [cnt_width-1:0]  instret
);

   typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

   localparam logic [1:0] SEL_LOAD = 2'd1;
   localparam logic [1:0] SEL_PC4  = 2'd2;

   state_t                state_q, state_d;
   logic                  reg_write_q, reg_write_d;
   logic [idx_width-1:0]  rd_q, rd_d;
   logic [1:0]            wb_sel_q, wb_sel_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [data_width-1:0] alu_q, alu_d;
   logic [data_width-1:0] pc_q, pc_d;
   logic [data_width-1:0] rdata_q, rdata_d;
   logic                  wb_en_q, wb_en_d;
   logic [idx_width-1:0]  wb_rd_q, wb_rd_d;
   logic [data_width-1:0] wb_data_q, wb_data_d;
   logic                  retire_q, retire_d;
   logic                  misaligned_q, misaligned_d;
   logic [cnt_width-1:0]  instret_q, instret_d;

   logic [1:0]            off;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [data_width-1:0] load_v;
   logic [data_width-1:0] result_v;
   logic                  mis_v;

   // Load extraction works on the captured address and the word latched in WAIT_LOAD.
   always_comb begin
      off    = alu_q[1:0];
      byte_v = rdata_q[7:0];
      case (off)
         2'd1:    byte_v = rdata_q[15:8];
         2'd2:    byte_v = rdata_q[23:16];
         2'd3:    byte_v = rdata_q[31:24];
         default: byte_v = rdata_q[7:0];
      endcase
      half_v = off[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (funct3_q)
         3'b000:  load_v = {{(data_width-8){byte_v[7]}}, byte_v};
         3'b001:  load_v = {{(data_width-16){half_v[15]}}, half_v};
         3'b100:  load_v = {{(data_width-8){1'b0}}, byte_v};
         3'b101:  load_v = {{(data_width-16){1'b0}}, half_v};
         default: load_v = rdata_q;
      endcase
      case (wb_sel_q)
         SEL_LOAD: result_v = load_v;
         SEL_PC4:  result_v = pc_q + data_width'(4);
         default:  result_v = alu_q;
      endcase
      mis_v = 1'b0;
      if (wb_sel_q == SEL_LOAD) begin
         case (funct3_q)
            3'b000, 3'b100: mis_v = 1'b0;
            3'b001, 3'b101: mis_v = off[0];
            default:        mis_v = (off != 2'd0);
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      reg_write_d  = reg_write_q;
      rd_d         = rd_q;
      wb_sel_d     = wb_sel_q;
      funct3_d     = funct3_q;
      alu_d        = alu_q;
      pc_d         = pc_q;
      rdata_d      = rdata_q;
      wb_en_d      = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      retire_d     = 1'b0;
      misaligned_d = 1'b0;
      instret_d    = instret_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               reg_write_d = in_reg_write;
               rd_d        = in_rd;
               wb_sel_d    = in_wb_sel;
               funct3_d    = in_funct3;
               alu_d       = in_alu_result;
               pc_d        = in_pc;
               state_d     = (in_wb_sel == SEL_LOAD) ? WAIT_LOAD : COMMIT;
            end
         end
         WAIT_LOAD: begin
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d      = IDLE;
            retire_d     = 1'b1;
            misaligned_d = mis_v;
            wb_en_d      = reg_write_q && (rd_q != '0) && !mis_v;
            wb_rd_d      = rd_q;
            wb_data_d    = mis_v ? '0 : result_v;
            instret_d    = instret_q + cnt_width'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         wb_sel_q     <= '0;
         funct3_q     <= '0;
         alu_q        <= '0;
         pc_q         <= '0;
         rdata_q      <= '0;
         wb_en_q      <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         retire_q     <= 1'b0;
         misaligned_q <= 1'b0;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         reg_write_q  <= reg_write_d;
         rd_q         <= rd_d;
         wb_sel_q     <= wb_sel_d;
         funct3_q     <= funct3_d;
         alu_q        <= alu_d;
         pc_q         <= pc_d;
         rdata_q      <= rdata_d;
         wb_en_q      <= wb_en_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         retire_q     <= retire_d;
         misaligned_q <= misaligned_d;
         instret_q    <= instret_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign wb_en      = wb_en_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign retire     = retire_q;
   assign misaligned = misaligned_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed-vector bench for writeback_stage.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result;
   logic [31:0] in_pc;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        retire;
   logic        misaligned;
   logic [63:0] instret;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_cnt = 0;

   writeback_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
      .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_pc(in_pc),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .retire(retire), .misaligned(misaligned), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_before_send", in_ready, 1);
      in_reg_write  = rw;
      in_rd         = rd;
      in_wb_sel     = sel;
      in_funct3     = f3;
      in_alu_result = alu;
      in_pc         = pc;
      in_valid      = 1'b1;
      tick();
      in_valid      = 1'b0;
   endtask

   task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                          input int idle, input logic [31:0] rdata);
      send(1'b1, rd, 2'd1, f3, addr, 32'h0);
      repeat (idle) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
      tick();
   endtask

   task automatic expect_wb(input string tag, input logic en, input logic [4:0] rd,
                            input logic [31:0] data, input logic mis);
      exp_cnt = exp_cnt + 1;
      check({tag, "_wb_en"}, wb_en, en);
      check({tag, "_retire"}, retire, 1);
      check({tag, "_misaligned"}, misaligned, mis);
      check({tag, "_wb_data"}, wb_data, data);
      if (en) check({tag, "_wb_rd"}, wb_rd, rd);
      check({tag, "_instret"}, instret, exp_cnt);
   endtask

   initial begin
      logic [31:0] burst_data [4];
      int          acc_cyc [4];
      int          ai, rc;
      logic        acc;

      rst = 1'b1;
      in_valid = 0; in_reg_write = 0; in_rd = 0; in_wb_sel = 0; in_funct3 = 0;
      in_alu_result = 0; in_pc = 0; mem_rvalid = 0; mem_rdata = 0;
      repeat (3) tick();
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_rd", wb_rd, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_retire", retire, 0);
      check("rst_misaligned", misaligned, 0);
      check("rst_instret", instret, 0);
      rst = 1'b0;
      tick();
      check("rst_in_ready", in_ready, 1);

      // ALU op: COMMIT cycle holds off input, write appears the cycle after.
      send(1'b1, 5'd5, 2'd0, 3'b000, 32'h1234_5678, 32'h0);
      check("alu_commit_ready", in_ready, 0);
      check("alu_commit_wb_en", wb_en, 0);
      tick();
      expect_wb("alu", 1, 5'd5, 32'h1234_5678, 0);
      check("alu_ready_after", in_ready, 1);
      tick();
      check("alu_pulse_retire", retire, 0);
      check("alu_pulse_wb_en", wb_en, 0);

      do_load(5'd7, 3'b000, 32'h0000_1003, 3, 32'h80FF_7F01);
      expect_wb("lb", 1, 5'd7, 32'hFFFF_FF80, 0);
      do_load(5'd7, 3'b100, 32'h0000_1003, 3, 32'h80FF_7F01);
      expect_wb("lbu", 1, 5'd7, 32'h0000_0080, 0);
      do_load(5'd8, 3'b000, 32'h0000_1001, 0, 32'h80FF_7F01);
      expect_wb("lb_off1", 1, 5'd8, 32'h0000_007F, 0);
      do_load(5'd9, 3'b001, 32'h0000_2002, 1, 32'hBEEF_1234);
      expect_wb("lh", 1, 5'd9, 32'hFFFF_BEEF, 0);
      do_load(5'd9, 3'b001, 32'h0000_2000, 0, 32'hBEEF_1234);
      expect_wb("lh_lo", 1, 5'd9, 32'h0000_1234, 0);
      do_load(5'd9, 3'b101, 32'h0000_2001, 0, 32'hBEEF_1234);
      expect_wb("lhu_mis", 0, 5'd9, 32'h0000_0000, 1);
      do_load(5'd3, 3'b010, 32'h0000_3000, 2, 32'hCAFE_F00D);
      expect_wb("lw", 1, 5'd3, 32'hCAFE_F00D, 0);
      do_load(5'd3, 3'b010, 32'h0000_3002, 0, 32'hCAFE_F00D);
      expect_wb("lw_mis", 0, 5'd3, 32'h0000_0000, 1);
      do_load(5'd4, 3'b111, 32'h0000_3000, 0, 32'h8765_4321);
      expect_wb("ld_undef", 1, 5'd4, 32'h8765_4321, 0);

      send(1'b1, 5'd1, 2'd2, 3'b000, 32'h0, 32'hFFFF_FFFC);
      tick();
      expect_wb("jal_wrap", 1, 5'd1, 32'h0000_0000, 0);
      send(1'b1, 5'd0, 2'd2, 3'b000, 32'h0, 32'h0000_0100);
      tick();
      expect_wb("jal_x0", 0, 5'd0, 32'h0000_0104, 0);
      send(1'b1, 5'd2, 2'd3, 3'b000, 32'h0BAD_F00D, 32'h0000_0200);
      tick();
      expect_wb("sel_rsvd", 1, 5'd2, 32'h0BAD_F00D, 0);

      // Back-to-back ALU ops with a stray mem_rvalid held high throughout.
      for (int i = 0; i < 4; i++) burst_data[i] = 32'hA000_0000 + 32'(i * 17);
      ai = 0; rc = 0;
      in_reg_write = 1'b1; in_wb_sel = 2'd0; in_funct3 = 3'b000; in_pc = 0;
      in_rd = 5'd10; in_alu_result = burst_data[0];
      in_valid = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      for (int cyc = 0; cyc < 30 && rc < 4; cyc++) begin
         acc = in_valid && in_ready;
         tick();
         if (retire) begin
            exp_cnt = exp_cnt + 1;
            check("burst_wb_data", wb_data, burst_data[rc]);
            check("burst_wb_rd", wb_rd, 64'(10 + rc));
            check("burst_instret", instret, exp_cnt);
            rc++;
         end
         if (acc) begin
            acc_cyc[ai] = cyc;
            ai++;
            if (ai < 4) begin
               in_rd = 5'(10 + ai);
               in_alu_result = burst_data[ai];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      mem_rvalid = 1'b0;
      check("burst_retires", 64'(rc), 4);
      check("burst_accepts", 64'(ai), 4);
      for (int i = 1; i < 4; i++) check("burst_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 2);

      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      mem_rvalid = 1'b0;
      check("stray_ready", in_ready, 1);
      check("stray_retire", retire, 0);
      tick();
      check("stray_retire2", retire, 0);
      check("stray_instret", instret, exp_cnt);

      // Reset while a load waits for data aborts it.
      send(1'b1, 5'd6, 2'd1, 3'b010, 32'h0000_4000, 32'h0);
      check("wait_ready", in_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      tick();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("abort_wb_en", wb_en, 0);
         check("abort_retire", retire, 0);
         tick();
      end
      check("abort_instret", instret, 0);
      check("abort_ready", in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core.
- Accepts one retiring instruction per handshake from the memory stage and waits for load data where needed.
- Aligns and extends load data, then drives the write port of the 32-entry register file (write enable, rd, rdv).
- Also flags misaligned loads and counts retired instructions.

Parameters:
- data_width, 32, datapath and register width.
- num_reg, 32, register count.
- idx_width, $clog2(num_reg), register index width.
- cnt_width, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  idx_width  destination register index.
- in_wb_sel  in  2  result select: 0=ALU, 1=LOAD, 2=PC+4, 3=reserved (treated as ALU).
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_alu_result  in  data_width  ALU result; for loads, the byte address.
- in_pc  in  data_width  instruction PC.
- mem_rvalid  in  1  load data valid (single-cycle pulse).
- mem_rdata  in  data_width  aligned 32-bit word containing the load target.
- wb_en  out  1  register-file write enable.
- wb_rd  out  idx_width  register-file destination index.
- wb_data  out  data_width  register-file write value.
- retire  out  1  one-cycle pulse per completed instruction.
- misaligned  out  1  one-cycle pulse with retire for a misaligned load.
- instret  out  cnt_width  retired-instruction count.

Behaviour:
- Reset (async, rst=1): state=IDLE; wb_en=0, wb_rd=0, wb_data=0, retire=0, misaligned=0, instret=0. in_ready reads 1 once rst deasserts.
- All outputs except in_ready are registered. in_ready = (state==IDLE), combinational from state.
- Capture: on posedge with in_valid && in_ready, latch all in_* fields.
- FSM transitions:
  - IDLE -> COMMIT when wb_sel != LOAD.
  - IDLE -> WAIT_LOAD when wb_sel == LOAD.
  - WAIT_LOAD -> COMMIT on mem_rvalid; mem_rdata is latched the same edge. WAIT_LOAD has no timeout.
  - COMMIT -> IDLE unconditionally.
- Outputs in COMMIT:
  - On the edge leaving COMMIT, outputs register so that wb_en/retire are high for exactly the one cycle after that edge.
  - Latency: non-load, accept edge to wb_en high = 2 cycles. Load, mem_rvalid edge to wb_en high = 2 cycles.
- Result select:
  - ALU: wb_data = alu_result.
  - PC+4: wb_data = pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Load extraction, with off = alu_result[1:0]:
  - Byte = rdata[8*off +: 8].
  - Half = rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata.
  - Undefined funct3 (011, 110, 111) is treated as LW.
- Misaligned load (LH/LHU with off[0]=1, or LW with off!=0):
  - No register write: wb_en=0.
  - misaligned=1 and retire=1 in the same cycle.
  - wb_data = 0.
- wb_en = reg_write && (rd != 0) && !misaligned. x0 is never written, but retire still pulses.
- instret increments by 1 on every retire cycle and wraps from all-ones to 0.
- Throughput: at most one instruction per 2 cycles for non-loads. in_valid while busy is held off by in_ready=0; no input is dropped.
- mem_rvalid outside WAIT_LOAD is ignored.
- rst mid-operation (WAIT_LOAD or COMMIT) aborts the instruction: no write, no retire, instret=0.

Test Plan:
- ALU op, rd=5, alu_result=0x12345678 -> two cycles after accept: wb_en=1, wb_rd=5, wb_data=0x12345678, retire=1, instret=1; in_ready=0 during COMMIT.
- LB, addr=0x1003, 3 idle cycles, then mem_rdata=0x80FF7F01 -> wb_data=0xFFFFFF80. Repeat as LBU -> wb_data=0x00000080.
- LH, addr=0x2002, mem_rdata=0xBEEF1234 -> wb_data=0xFFFFBEEF. LHU, addr=0x2001 -> misaligned=1, retire=1, wb_en=0.
- JAL-style (wb_sel=PC+4), pc=0xFFFFFFFC, rd=1 -> wb_data=0x00000000. Same with rd=0 -> wb_en=0, retire=1, instret increments.
- Back-to-back in_valid for 4 ALU ops -> accepted on alternate cycles, 4 retire pulses, instret=4. A stray mem_rvalid in IDLE has no effect.
- Assert rst while in WAIT_LOAD, then deliver mem_rvalid after deassert -> no wb_en, no retire, instret=0, in_ready=1.
